// File: rtl/serial_frame_tx_if.sv
// Upstream word handshake between a word source and serial_frame_tx.
// The source drives in_valid/in_data/in_last; the transmitter returns
// in_ack combinationally in the same cycle.
interface serial_frame_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             in_ack;

  // Word source side
  modport master (
    output in_valid,
    output in_data,
    output in_last,
    input  in_ack
  );

  // Transmitter side
  modport slave (
    input  in_valid,
    input  in_data,
    input  in_last,
    output in_ack
  );
endinterface

// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: accepts parallel words on a valid/ack
// handshake and shifts them MSB-first onto a tri-stated data line.
// Frames are delimited by active, individual bits are qualified by ready.
// Optional feature macro: SERIAL_FRAME_TX_PARITY_EN appends one even-parity
// bit after every word (word length becomes WIDTH+1 bit cycles).
module serial_frame_tx #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned GAP_MAX = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_frame_tx_if.slave up,
  output logic             active,
  output logic             ready,
  output tri               data,
  output logic             busy
);

`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int unsigned NBITS = WIDTH + 1;
`else
  localparam int unsigned NBITS = WIDTH;
`endif
  localparam int unsigned CNT_W = $clog2(NBITS + 1);
  localparam int unsigned GAP_W = $clog2(GAP_MAX + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t           state;
  logic [NBITS-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             last_q;
  logic             final_bit;
  logic             accept;
  logic [NBITS-1:0] load_word;

  // Word as it enters the shift register; parity rides as the trailing bit
`ifdef SERIAL_FRAME_TX_PARITY_EN
  assign load_word = {up.in_data, ^up.in_data};
`else
  assign load_word = up.in_data;
`endif

  // Last bit cycle of the current word (parity cycle when enabled)
  assign final_bit = (state == SEND) && (bit_cnt == CNT_W'(NBITS - 1));

  // Ack is open in IDLE, WAIT and on the final bit of a non-last word;
  // held low while reset is asserted so a partial handshake is never taken
  assign up.in_ack = rst_n && up.in_valid &&
                     ((state == IDLE) || (state == WAIT) || (final_bit && !last_q));
  assign accept    = up.in_ack;

  // Data line is only driven while a bit is being qualified
  assign data = (active && ready) ? shreg[NBITS-1] : 1'bz;

  // Frame sequencing with registered link outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      active  <= 1'b0;
      ready   <= 1'b0;
      busy    <= 1'b0;
      shreg   <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shreg   <= load_word;
            last_q  <= up.in_last;
            bit_cnt <= '0;
            state   <= START;
            active  <= 1'b1;
            busy    <= 1'b1;
          end
        end
        START: begin
          state <= SEND;
          ready <= 1'b1;
        end
        SEND: begin
          if (final_bit) begin
            if (last_q) begin
              state  <= IDLE;
              active <= 1'b0;
              ready  <= 1'b0;
              busy   <= 1'b0;
            end else if (accept) begin
              // back-to-back word: no gap, ready stays high
              shreg   <= load_word;
              last_q  <= up.in_last;
              bit_cnt <= '0;
            end else begin
              state   <= WAIT;
              ready   <= 1'b0;
              gap_cnt <= GAP_W'(1);
            end
          end else begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end
        WAIT: begin
          if (accept) begin
            shreg   <= load_word;
            last_q  <= up.in_last;
            bit_cnt <= '0;
            state   <= SEND;
            ready   <= 1'b1;
          end else if (gap_cnt == GAP_W'(GAP_MAX)) begin
            // inter-word gap exhausted: close the frame
            state  <= IDLE;
            active <= 1'b0;
            busy   <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          active <= 1'b0;
          ready  <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Self-checking bench for serial_frame_tx: expected serial bits are queued
// when a word is accepted and compared as qualified bits appear on the link.
module tb_serial_frame_tx;

  localparam int unsigned WIDTH   = 8;
  localparam int unsigned GAP_MAX = 4;
`ifdef SERIAL_FRAME_TX_PARITY_EN
  localparam int unsigned NB = WIDTH + 1;
`else
  localparam int unsigned NB = WIDTH;
`endif

  logic clk;
  logic rst_n;
  logic active;
  logic ready;
  logic busy;
  wire  data;

  serial_frame_tx_if #(.WIDTH(WIDTH)) up ();

  serial_frame_tx #(.WIDTH(WIDTH), .GAP_MAX(GAP_MAX)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .up     (up.slave),
    .active (active),
    .ready  (ready),
    .data   (data),
    .busy   (busy)
  );

  int   n_vec;
  int   n_err;
  logic sb[$];
  logic mon_en;
  logic prev_active;
  logic prev_ready;
  int   gap_run;
  int   waited;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: count and report mismatches
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected bit stream of one word, MSB first, then even parity if enabled
  function automatic void push_word(input logic [WIDTH-1:0] w);
    logic p;
    p = 1'b0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      sb.push_back(w[i]);
      p = p ^ w[i];
    end
`ifdef SERIAL_FRAME_TX_PARITY_EN
    sb.push_back(p);
`endif
  endfunction

  // Scoreboard feed: any handshake completing at this edge queues its bits
  always @(posedge clk) begin
    if (up.in_valid && up.in_ack)
      push_word(up.in_data);
  end

  // Link monitor: bit scoreboard plus link-level rules every cycle
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      check("busy_vs_active", busy, active);
      check("ready_wo_active", ready & ~active, 1'b0);
      if (!prev_active && !prev_ready)
        check("ready_after_idle", ready, 1'b0);
      if (prev_active && !active)
        check("ready_after_end", ready, 1'b0);
      if (active && !ready) gap_run++;
      else gap_run = 0;
      if (active && !ready)
        check("gap_run_ok", 32'(gap_run <= int'(GAP_MAX)), 32'd1);
      if (active && ready) begin
        if (sb.size() == 0) check("sb_underflow", 1'b1, 1'b0);
        else check("bit", data, sb.pop_front());
      end
    end
    prev_active = active;
    prev_ready  = ready;
  end

  // One clock: check registered link state just after the edge
  task automatic step(input logic a, input logic r, input string tag);
    @(posedge clk);
    #1;
    check({tag, "_active"}, active, a);
    check({tag, "_ready"}, ready, r);
  endtask

  // Complete single-word frame from IDLE with cycle-exact link checks
  task automatic send_single(input logic [WIDTH-1:0] w);
    @(negedge clk);
    up.in_valid = 1'b1;
    up.in_data  = w;
    up.in_last  = 1'b1;
    #1 check("single_ack", up.in_ack, 1'b1);
    step(1'b1, 1'b0, "single_start");
    @(negedge clk);
    up.in_valid = 1'b0;
    #1 check("single_start_ack", up.in_ack, 1'b0);
    for (int i = 0; i < int'(NB); i++) step(1'b1, 1'b1, "single_send");
    step(1'b0, 1'b0, "single_end");
    check("single_sb_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec       = 0;
    n_err       = 0;
    mon_en      = 1'b0;
    prev_active = 1'b0;
    prev_ready  = 1'b0;
    gap_run     = 0;
    rst_n       = 1'b0;
    up.in_valid = 1'b0;
    up.in_data  = '0;
    up.in_last  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_active", active, 1'b0);
    check("rst_ready", ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_ack", up.in_ack, 1'b0);
    mon_en = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single word, last
    send_single(8'hA5);
    repeat (2) @(negedge clk);

    // Two words back-to-back with valid held
    up.in_valid = 1'b1;
    up.in_data  = 8'h3C;
    up.in_last  = 1'b0;
    #1 check("b2b_ack1", up.in_ack, 1'b1);
    step(1'b1, 1'b0, "b2b_start");
    @(negedge clk);
    up.in_data = 8'hF0;
    up.in_last = 1'b1;
    #1 check("b2b_start_ack", up.in_ack, 1'b0);
    for (int i = 0; i < int'(NB); i++) begin
      step(1'b1, 1'b1, "b2b_w1");
      @(negedge clk);
      #1 check("b2b_ack2", up.in_ack, 32'(i == int'(NB) - 1));
    end
    for (int i = 0; i < int'(NB); i++) begin
      step(1'b1, 1'b1, "b2b_w2");
      if (i == 0) begin
        @(negedge clk);
        up.in_valid = 1'b0;
      end
    end
    step(1'b0, 1'b0, "b2b_end");
    check("b2b_sb_empty", sb.size(), 0);
    repeat (2) @(negedge clk);

    // Non-last word then nothing: full gap, frame closes
    up.in_valid = 1'b1;
    up.in_data  = 8'h81;
    up.in_last  = 1'b0;
    #1 check("gap_ack", up.in_ack, 1'b1);
    step(1'b1, 1'b0, "gap_start");
    @(negedge clk);
    up.in_valid = 1'b0;
    for (int i = 0; i < int'(NB); i++) step(1'b1, 1'b1, "gap_send");
    for (int i = 0; i < int'(GAP_MAX); i++) step(1'b1, 1'b0, "gap_wait");
    step(1'b0, 1'b0, "gap_end");
    check("gap_sb_empty", sb.size(), 0);
    repeat (2) @(negedge clk);

    // Non-last word, next word accepted on the second WAIT cycle
    up.in_valid = 1'b1;
    up.in_data  = 8'h55;
    up.in_last  = 1'b0;
    #1 check("wacc_ack1", up.in_ack, 1'b1);
    step(1'b1, 1'b0, "wacc_start");
    @(negedge clk);
    up.in_valid = 1'b0;
    for (int i = 0; i < int'(NB); i++) step(1'b1, 1'b1, "wacc_w1");
    step(1'b1, 1'b0, "wacc_wait1");
    step(1'b1, 1'b0, "wacc_wait2");
    @(negedge clk);
    up.in_valid = 1'b1;
    up.in_data  = 8'h0F;
    up.in_last  = 1'b1;
    #1 check("wacc_ack2", up.in_ack, 1'b1);
    step(1'b1, 1'b1, "wacc_resume");
    @(negedge clk);
    up.in_valid = 1'b0;
    for (int i = 1; i < int'(NB); i++) step(1'b1, 1'b1, "wacc_w2");
    step(1'b0, 1'b0, "wacc_end");
    check("wacc_sb_empty", sb.size(), 0);
    repeat (2) @(negedge clk);

    // Reset during bit 4, then a clean word
    up.in_valid = 1'b1;
    up.in_data  = 8'hC3;
    up.in_last  = 1'b1;
    #1 check("mrst_ack", up.in_ack, 1'b1);
    step(1'b1, 1'b0, "mrst_start");
    @(negedge clk);
    up.in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, "mrst_send");
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    step(1'b0, 1'b0, "mrst_hit");
    check("mrst_busy", busy, 1'b0);
    @(negedge clk);
    up.in_valid = 1'b1;
    up.in_data  = 8'hFF;
    #1 check("mrst_noack", up.in_ack, 1'b0);
    @(negedge clk);
    up.in_valid = 1'b0;
    rst_n       = 1'b1;
    send_single(8'h96);
    repeat (2) @(negedge clk);

    // Parity-sensitive words (odd and even number of ones)
    send_single(8'h07);
    send_single(8'h03);
    repeat (2) @(negedge clk);

    // Random words with random inter-word spacing
    for (int w = 0; w < 24; w++) begin
      @(negedge clk);
      up.in_valid = 1'b1;
      up.in_data  = WIDTH'($urandom);
      up.in_last  = ($urandom_range(0, 3) == 0);
      waited = 0;
      #1;
      while (!up.in_ack && waited < 40) begin
        @(negedge clk);
        #1;
        waited++;
      end
      check("rnd_ack_in_time", 32'(waited < 40), 32'd1);
      @(posedge clk);
      @(negedge clk);
      up.in_valid = 1'b0;
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    waited = 0;
    while (busy && waited < 100) begin
      @(posedge clk);
      #1;
      waited++;
    end
    check("rnd_drain_busy", busy, 1'b0);
    check("rnd_sb_empty", sb.size(), 0);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/serial_frame_tx.md
# serial_frame_tx

Framed serial transmitter that drives the `active`/`ready`/`data` link consumed by the downstream link checker/receiver. Accepts parallel words over a valid/ack handshake and shifts them MSB-first onto a single tri-stated data line. Frames are delimited by `active`; individual bits are qualified by `ready`. All link-protocol rules enforced at that interface are guaranteed by construction here.

## Interface
- `WIDTH`, 8, bits per word (≥2)
- `GAP_MAX`, 4, maximum inter-word wait cycles inside a frame (legal 1..4)

- `clk`  in  1  single clock, all logic on posedge
- `rst_n`  in  1  synchronous, active-low reset
- `in_valid`  in  1  upstream word available
- `in_data`  in  WIDTH  word to send
- `in_last`  in  1  word is last of frame; qualified by `in_valid`
- `in_ack`  out  1  combinational; word sampled at the posedge where `in_valid && in_ack`
- `active`  out  1  frame in progress (registered)
- `ready`  out  1  `data` carries a valid bit this cycle (registered)
- `data`  out  1  serial bit when `active && ready`, else `'z`
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE (active=0, ready=0), START (1,0), SEND (1,1), WAIT (1,0).
- IDLE: `in_ack = in_valid`. On accept: load shift register with `in_data`, latch `in_last` into `last_q`, clear bit counter, go START.
- START: exactly one cycle, then SEND.
- SEND: `data = shreg[MSB]`, shift left each cycle, bit counter increments. On the final bit cycle:
  - `last_q=1` → IDLE (active and ready fall together); `in_ack=0`.
  - else `in_ack = in_valid`; if accepted, reload and stay SEND (no gap); else go WAIT with gap counter = 1.
- WAIT: `in_ack = in_valid`. If accepted → reload, SEND next cycle. Else if gap counter == GAP_MAX → IDLE; else increment.
- `in_ack` is 0 in START and in SEND except the final bit cycle.
- `data` is `'z` in every state except SEND; never `'x`.
- Guaranteed link properties: `!active || !ready` ⇒ `data=='z`; at most GAP_MAX (<5) consecutive cycles of `active && !ready`; from `!active && !ready`, `ready` is 0 next cycle (ready only rises after START); the cycle after `active` falls, `ready` is 0.
- Reset (any state, incl. mid-word): next posedge → IDLE, active=0, ready=0, data='z', counters and `last_q` cleared; partial word discarded, no ack.
- `in_data`/`in_last` ignored when `in_ack=0`.

## Timing
- Reset values: active=0, ready=0, busy=0, data='z, in_ack=0 (with in_valid=0).
- Word accepted in IDLE at edge t: START in cycle t+1, bits MSB..LSB in cycles t+2..t+WIDTH+1.
- Back-to-back words: zero idle cycles between last bit of word N and first bit of word N+1.
- WAIT accept at WAIT cycle k (1..GAP_MAX): SEND next cycle.
- Frame end: one cycle after final bit (or after GAP_MAX-th WAIT cycle) active=0; earliest new accept in that IDLE cycle, so minimum one idle cycle between frames.

## Configuration
- `SERIAL_FRAME_TX_PARITY_EN` defined: each word is followed by one extra SEND cycle carrying even parity (XOR of all WIDTH bits); "final bit cycle" above becomes the parity cycle; word length WIDTH+1 cycles.
- Undefined: no parity bit, WIDTH cycles per word.

## Test plan
- Single word 0xA5, in_last=1, from reset: ack at t, START t+1, data 1,0,1,0,0,1,0,1 in t+2..t+9, active=0 at t+10; data='z outside SEND.
- Two words 0x3C,0xF0 (second last) with in_valid held: second ack on final bit of first, 16 contiguous ready=1 cycles, then IDLE.
- Word 0x81 not last, in_valid low afterwards: WAIT for exactly 4 cycles (active=1, ready=0), then active=0; never 5 active&&!ready cycles.
- Word 0x55 not last, next word 0x0F after 2 WAIT cycles: ack on WAIT cycle 2, SEND resumes next cycle, frame ends after 0x0F if last.
- rst_n=0 during bit 4 of 0xC3: next edge active=0, ready=0, data='z, busy=0; fresh word after release transmits cleanly.
- With `SERIAL_FRAME_TX_PARITY_EN`: 0x07 last → 9 SEND cycles, ninth bit = 1; 0x03 → ninth bit = 0.
